// File: rtl/i2c_target_regs.sv
// I2C target that maps bus transfers onto a byte-wide register port.
// Writes: first byte loads the pointer, following bytes store at it. Reads stream from the pointer.
module i2c_target_regs #(
    parameter logic [6:0] TARGET_ADDR = 7'h42,
    parameter int         REG_ADDR_W  = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_oe,
    output logic [REG_ADDR_W-1:0] reg_addr,
    output logic [7:0]            reg_wdata,
    output logic                  reg_we,
    input  logic [7:0]            reg_rdata,
    output logic                  busy
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
    } state_t;

    localparam logic [REG_ADDR_W-1:0] ADDR_INC = {{(REG_ADDR_W-1){1'b0}}, 1'b1};

    state_t     state;
    logic       scl_p0, scl_p1, scl_p2;
    logic       sda_p0, sda_p1, sda_p2;
    logic [3:0] bit_cnt;
    logic [7:0] shift;
    logic       mack;
    logic       scl_rise, scl_fall, start_det, stop_det, shift_in, load_rd;

    // Stage p0/p1: two-flop synchronizer; p2: previous sample for edge detect.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scl_p0 <= 1'b1;
            scl_p1 <= 1'b1;
            scl_p2 <= 1'b1;
            sda_p0 <= 1'b1;
            sda_p1 <= 1'b1;
            sda_p2 <= 1'b1;
        end else begin
            scl_p0 <= scl_in;
            scl_p1 <= scl_p0;
            scl_p2 <= scl_p1;
            sda_p0 <= sda_in;
            sda_p1 <= sda_p0;
            sda_p2 <= sda_p1;
        end
    end

    // START/STOP need SCL high on both samples, so any SCL edge suppresses them.
    assign scl_rise  = scl_p1 & ~scl_p2;
    assign scl_fall  = ~scl_p1 & scl_p2;
    assign start_det = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
    assign stop_det  = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;

    assign shift_in = scl_rise && (bit_cnt != 4'd8) &&
                      (state == ADDR || state == PTR || state == WDATA);
    assign load_rd  = scl_fall && ((state == ADDR_ACK && shift[0]) ||
                                   (state == RDATA_ACK && mack));

    always_ff @(posedge clock) begin
        if (shift_in)
            shift <= {shift[6:0], sda_p1};
        else if (load_rd)
            shift <= reg_rdata;
        else if (scl_fall && state == RDATA && bit_cnt != 4'd8)
            shift <= {shift[6:0], 1'b0};
    end

    // Stage p3: protocol FSM acting on detected edges.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            sda_oe    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= 8'h00;
            reg_we    <= 1'b0;
            busy      <= 1'b0;
            bit_cnt   <= 4'd0;
            mack      <= 1'b0;
        end else begin
            reg_we <= 1'b0;
            if (start_det) begin
                state   <= ADDR;
                sda_oe  <= 1'b0;
                bit_cnt <= 4'd0;
            end else if (stop_det) begin
                state   <= IDLE;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
                bit_cnt <= 4'd0;
            end else if (scl_rise) begin
                if (shift_in) begin
                    bit_cnt <= bit_cnt + 4'd1;
                    if (state == WDATA && bit_cnt == 4'd7) begin
                        reg_wdata <= {shift[6:0], sda_p1};
                        reg_we    <= 1'b1;
                    end
                end
                if (state == RDATA_ACK) begin
                    mack     <= ~sda_p1;
                    reg_addr <= reg_addr + ADDR_INC;
                end
            end else if (scl_fall) begin
                if (load_rd) begin
                    sda_oe  <= ~reg_rdata[7];
                    bit_cnt <= 4'd1;
                    state   <= RDATA;
                end else begin
                    case (state)
                        ADDR: if (bit_cnt == 4'd8) begin
                            bit_cnt <= 4'd0;
                            if (shift[7:1] == TARGET_ADDR) begin
                                sda_oe <= 1'b1;
                                busy   <= 1'b1;
                                state  <= ADDR_ACK;
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end
                        ADDR_ACK: begin
                            sda_oe <= 1'b0;
                            state  <= PTR;
                        end
                        PTR: if (bit_cnt == 4'd8) begin
                            reg_addr <= shift[REG_ADDR_W-1:0];
                            sda_oe   <= 1'b1;
                            bit_cnt  <= 4'd0;
                            state    <= PTR_ACK;
                        end
                        PTR_ACK: begin
                            sda_oe <= 1'b0;
                            state  <= WDATA;
                        end
                        WDATA: if (bit_cnt == 4'd8) begin
                            sda_oe  <= 1'b1;
                            bit_cnt <= 4'd0;
                            state   <= WDATA_ACK;
                        end
                        WDATA_ACK: begin
                            sda_oe   <= 1'b0;
                            reg_addr <= reg_addr + ADDR_INC;
                            state    <= WDATA;
                        end
                        RDATA: if (bit_cnt == 4'd8) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= 4'd0;
                            state   <= RDATA_ACK;
                        end else begin
                            sda_oe  <= ~shift[6];
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                        RDATA_ACK: begin
                            sda_oe <= 1'b0;
                            state  <= WAIT_STOP;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-level I2C controller plus a register-file reference model.
module tb_i2c_target_regs;
    localparam int H = 8;

    logic        clock    = 1'b0;
    logic        reset_n  = 1'b0;
    logic        scl_ctrl = 1'b1;
    logic        sda_ctrl = 1'b1;
    logic        sda_line;
    logic        sda_oe, reg_we, busy;
    logic [3:0]  reg_addr;
    logic [7:0]  reg_wdata, reg_rdata;
    logic        fmode = 1'b0;
    logic [7:0]  mem [16] = '{default: 8'h00};
    logic [11:0] we_log [1024];
    int          we_cnt = 0;
    int          oe_cnt = 0;
    int          n_chk  = 0;
    int          n_err  = 0;

    always #5 clock = ~clock;

    assign sda_line  = sda_ctrl & ~sda_oe;
    assign reg_rdata = fmode ? ({4'h0, reg_addr} ^ 8'hC3) : mem[reg_addr];

    i2c_target_regs #(.TARGET_ADDR(7'h42), .REG_ADDR_W(4)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .scl_in    (scl_ctrl),
        .sda_in    (sda_line),
        .sda_oe    (sda_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    // User register file and write log; every high cycle of reg_we is logged.
    always @(negedge clock) begin
        if (reg_we) begin
            we_log[10'(we_cnt)] <= {reg_addr, reg_wdata};
            mem[reg_addr]       <= reg_wdata;
            we_cnt              <= we_cnt + 1;
        end
        if (sda_oe) oe_cnt <= oe_cnt + 1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic hw(input int n = H);
        repeat (n) @(negedge clock);
    endtask

    task automatic i2c_start();
        sda_ctrl = 1'b1; hw();
        scl_ctrl = 1'b1; hw();
        sda_ctrl = 1'b0; hw();
        scl_ctrl = 1'b0; hw();
    endtask

    task automatic i2c_stop();
        sda_ctrl = 1'b0; hw();
        scl_ctrl = 1'b1; hw();
        sda_ctrl = 1'b1; hw();
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            sda_ctrl = b[7-i]; hw();
            scl_ctrl = 1'b1;   hw();
            scl_ctrl = 1'b0;
        end
    endtask

    task automatic write_byte(input logic [7:0] b, output bit ack);
        send_bits(b, 8);
        sda_ctrl = 1'b1; hw();
        scl_ctrl = 1'b1; hw(H/2);
        ack = !sda_line; hw(H/2);
        scl_ctrl = 1'b0;
    endtask

    task automatic read_byte(input bit give_ack, output logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            sda_ctrl = 1'b1; hw();
            scl_ctrl = 1'b1; hw(H/2);
            b[7-i] = sda_line; hw(H/2);
            scl_ctrl = 1'b0;
        end
        sda_ctrl = !give_ack; hw();
        scl_ctrl = 1'b1;      hw();
        scl_ctrl = 1'b0;
    endtask

    initial begin
        logic [7:0]  model_mem [16];
        logic [3:0]  mptr;
        logic [11:0] exp_w [4];
        logic [7:0]  d, p;
        logic [6:0]  a7;
        bit          a;
        int          n, kind, mark, omark;

        for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
        mptr = 4'h0;

        hw(4);
        check_eq("rst sda_oe", 32'(sda_oe), 0);
        check_eq("rst reg_addr", 32'(reg_addr), 0);
        check_eq("rst reg_wdata", 32'(reg_wdata), 0);
        check_eq("rst reg_we", 32'(reg_we), 0);
        check_eq("rst busy", 32'(busy), 0);
        reset_n = 1'b1;
        hw(4);

        // Directed write: ptr 3, data A5, 5A
        mark = we_cnt;
        i2c_start();
        write_byte(8'h84, a); check_eq("wr addr ack", 32'(a), 1);
        check_eq("wr busy", 32'(busy), 1);
        write_byte(8'h03, a); check_eq("wr ptr ack", 32'(a), 1);
        write_byte(8'hA5, a); check_eq("wr d0 ack", 32'(a), 1);
        write_byte(8'h5A, a); check_eq("wr d1 ack", 32'(a), 1);
        i2c_stop(); hw(4);
        check_eq("wr busy after stop", 32'(busy), 0);
        check_eq("wr we count", 32'(we_cnt - mark), 2);
        check_eq("wr we0", 32'(we_log[10'(mark)]), 'h3A5);
        check_eq("wr we1", 32'(we_log[10'(mark + 1)]), 'h45A);
        model_mem[3] = 8'hA5; model_mem[4] = 8'h5A; mptr = 4'h5;
        check_eq("wr reg_addr", 32'(reg_addr), 32'(mptr));

        // Address miss
        mark = we_cnt; omark = oe_cnt;
        i2c_start();
        write_byte(8'h86, a); check_eq("miss addr ack", 32'(a), 0);
        check_eq("miss busy", 32'(busy), 0);
        write_byte(8'h00, a);
        i2c_stop(); hw(4);
        check_eq("miss oe cycles", 32'(oe_cnt - omark), 0);
        check_eq("miss we count", 32'(we_cnt - mark), 0);
        check_eq("miss reg_addr", 32'(reg_addr), 32'(mptr));

        // Combined read with pointer wrap, formula-driven read data
        fmode = 1'b1;
        i2c_start();
        write_byte(8'h84, a); check_eq("cr addr ack", 32'(a), 1);
        write_byte(8'h0E, a); check_eq("cr ptr ack", 32'(a), 1);
        i2c_start();
        write_byte(8'h85, a); check_eq("cr raddr ack", 32'(a), 1);
        read_byte(1'b1, d); check_eq("cr byte0", 32'(d), 'hCD);
        read_byte(1'b1, d); check_eq("cr byte1", 32'(d), 'hCC);
        read_byte(1'b0, d); check_eq("cr byte2", 32'(d), 'hC3);
        hw(4);
        check_eq("cr oe after nack", 32'(sda_oe), 0);
        i2c_stop(); hw(4);
        check_eq("cr reg_addr wrap", 32'(reg_addr), 1);
        check_eq("cr busy", 32'(busy), 0);
        fmode = 1'b0; mptr = 4'h1;

        // Abort mid data byte
        mark = we_cnt;
        i2c_start();
        write_byte(8'h84, a);
        write_byte(8'h07, a);
        send_bits(8'hFF, 5);
        i2c_stop(); hw(4);
        check_eq("abort we count", 32'(we_cnt - mark), 0);
        check_eq("abort sda_oe", 32'(sda_oe), 0);
        check_eq("abort busy", 32'(busy), 0);
        check_eq("abort reg_addr", 32'(reg_addr), 7);
        mptr = 4'h7;

        // Asynchronous reset while ACK is driven
        i2c_start();
        send_bits(8'h84, 8);
        sda_ctrl = 1'b1; hw();
        check_eq("rstack oe before", 32'(sda_oe), 1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("rstack sda_oe", 32'(sda_oe), 0);
        check_eq("rstack reg_addr", 32'(reg_addr), 0);
        check_eq("rstack busy", 32'(busy), 0);
        @(negedge clock);
        scl_ctrl = 1'b1; sda_ctrl = 1'b1; hw(4);
        reset_n = 1'b1; hw(4);
        mptr = 4'h0;

        // Randomized transactions against the register-file model
        for (int t = 0; t < 20; t++) begin
            kind = (t == 0) ? 2 : int'($urandom_range(0, 3));
            n = int'($urandom_range(1, 4));
            mark = we_cnt; omark = oe_cnt;
            case (kind)
                0: begin
                    p = 8'($urandom);
                    i2c_start();
                    write_byte(8'h84, a); check_eq("rw addr ack", 32'(a), 1);
                    write_byte(p, a);     check_eq("rw ptr ack", 32'(a), 1);
                    mptr = p[3:0];
                    for (int i = 0; i < n; i++) begin
                        d = 8'($urandom);
                        write_byte(d, a); check_eq("rw data ack", 32'(a), 1);
                        exp_w[i] = {mptr, d};
                        model_mem[mptr] = d;
                        mptr = mptr + 4'h1;
                    end
                    i2c_stop(); hw(4);
                    check_eq("rw we count", 32'(we_cnt - mark), 32'(n));
                    for (int i = 0; i < n; i++)
                        check_eq("rw we entry", 32'(we_log[10'(mark + i)]), 32'(exp_w[i]));
                end
                1, 2: begin
                    i2c_start();
                    if (kind == 1) begin
                        p = 8'($urandom);
                        write_byte(8'h84, a); check_eq("rr addr ack", 32'(a), 1);
                        write_byte(p, a);     check_eq("rr ptr ack", 32'(a), 1);
                        mptr = p[3:0];
                        i2c_start();
                    end
                    write_byte(8'h85, a); check_eq("rr raddr ack", 32'(a), 1);
                    for (int i = 0; i < n; i++) begin
                        read_byte(i != n - 1, d);
                        check_eq("rr data", 32'(d), 32'(model_mem[mptr]));
                        mptr = mptr + 4'h1;
                    end
                    i2c_stop(); hw(4);
                    check_eq("rr we count", 32'(we_cnt - mark), 0);
                end
                default: begin
                    a7 = 7'($urandom);
                    if (a7 == 7'h42) a7 = 7'h43;
                    i2c_start();
                    write_byte({a7, 1'($urandom)}, a); check_eq("rm addr ack", 32'(a), 0);
                    write_byte(8'($urandom), a);
                    i2c_stop(); hw(4);
                    check_eq("rm oe cycles", 32'(oe_cnt - omark), 0);
                    check_eq("rm we count", 32'(we_cnt - mark), 0);
                end
            endcase
            check_eq("rnd reg_addr", 32'(reg_addr), 32'(mptr));
            check_eq("rnd busy", 32'(busy), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
